tone_detector: RTL



---
 rtl/discrete_pkg.sv | 17 +
 rtl/peak_envelope_follower.sv | 30 +++
 rtl/tone_detector.sv | 138 +++++++++++++
 3 files changed

// File: rtl/discrete_pkg.sv
// Shared types and helpers for the discrete sound receive/generate blocks.
package discrete_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} tone_state_t;

  localparam int SAMPLE_MAX = 32767;

  // Clamp an 18-bit intermediate into the 16-bit sample range.
  function automatic sample_t sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sd32767;
    else if (v < -18'sd32768) return -16'sd32768;
    else                      return sample_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/peak_envelope_follower.sv
// Peak-hold envelope with exponential decay; |x| saturates so -32768 reads as 32767.
module peak_envelope_follower
  import discrete_pkg::*;
#(
  parameter int DECAY_SHIFT = 6
) (
  input  logic        clk,
  input  logic        I_RSTn,
  input  logic        en,
  input  sample_t     x,
  output logic [15:0] env,
  output logic [15:0] env_nxt
);

  logic [15:0] a;

  always_comb begin
    if (x == -16'sd32768) a = 16'(SAMPLE_MAX);
    else if (x[15])       a = 16'(-x);
    else                  a = 16'(x);
    // The decrement floors, so small envelopes stall above zero rather than underflow.
    env_nxt = (a > env) ? a : env - (env >> DECAY_SHIFT);
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn)  env <= '0;
    else if (en)  env <= env_nxt;
  end

endmodule

// File: rtl/tone_detector.sv
// Recovers a tone gate and its period (in samples) from a signed audio stream.
// Optional TONE_DETECTOR_DC_BLOCK_EN inserts a first-order DC blocker ahead of everything.
module tone_detector
  import discrete_pkg::*;
#(
  parameter int SAMPLE_RATE = 48000,
  parameter int HYST        = 256,
  parameter int ENV_ON      = 2048,
  parameter int ENV_OFF     = 1024,
  parameter int DECAY_SHIFT = 6,
  parameter int MIN_PERIOD  = 4,
  parameter int MAX_PERIOD  = 2400,
  parameter int LOCK_COUNT  = 3,
  parameter int TOL_SHIFT   = 3
) (
  input  logic        clk,
  input  logic        I_RSTn,
  input  logic        audio_clk_en,
  input  sample_t     in,
  output logic        tone_present,
  output logic [15:0] period,
  output logic        period_valid,
  output logic [15:0] envelope
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  sample_t     x;
  logic [15:0] env, env_nxt;
  logic        sq, sq_nxt, rise, p_ok, p_match, rel;
  logic [15:0] cnt, cnt_nxt, ref_p, p_diff;
  logic [MW-1:0] match_cnt;
  tone_state_t state;

`ifdef TONE_DETECTOR_DC_BLOCK_EN
  sample_t            x1, y1;
  logic signed [17:0] y_full;

  always_comb y_full = 18'(in) - 18'(x1) + 18'(y1) - 18'(y1 >>> 8);

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      x1 <= '0;
      y1 <= '0;
    end else if (audio_clk_en) begin
      x1 <= in;
      y1 <= sat16(y_full);
    end
  end

  // Downstream sees the registered filter output: one sample of added latency.
  assign x = y1;
`else
  assign x = in;
`endif

  peak_envelope_follower #(.DECAY_SHIFT(DECAY_SHIFT)) u_env (
    .clk     (clk),
    .I_RSTn  (I_RSTn),
    .en      (audio_clk_en),
    .x       (x),
    .env     (env),
    .env_nxt (env_nxt)
  );

  assign envelope = env;

  always_comb begin
    sq_nxt = sq;
    if (x > HYST)       sq_nxt = 1'b1;
    else if (x < -HYST) sq_nxt = 1'b0;
    rise = sq_nxt & ~sq;

    if (rise)                           cnt_nxt = 16'd1;
    else if (cnt >= 16'(MAX_PERIOD))    cnt_nxt = 16'(MAX_PERIOD);
    else                                cnt_nxt = cnt + 16'd1;

    // cnt before the edge update is the measured period.
    p_ok    = rise && (cnt >= 16'(MIN_PERIOD)) && (cnt < 16'(MAX_PERIOD));
    p_diff  = (cnt >= ref_p) ? cnt - ref_p : ref_p - cnt;
    p_match = p_diff <= (ref_p >> TOL_SHIFT);
    rel     = (env_nxt < 16'(ENV_OFF)) || (cnt_nxt == 16'(MAX_PERIOD));
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state        <= IDLE;
      sq           <= 1'b0;
      cnt          <= '0;
      ref_p        <= '0;
      match_cnt    <= '0;
      tone_present <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (audio_clk_en) begin
        sq  <= sq_nxt;
        cnt <= cnt_nxt;
        if (p_ok) begin
          period_valid <= 1'b1;
          period       <= cnt;
        end
        case (state)
          IDLE: begin
            if (p_ok && env_nxt >= 16'(ENV_ON)) begin
              state     <= TRACK;
              ref_p     <= cnt;
              match_cnt <= MW'(1);
            end
          end
          default: begin
            // Release wins over a coincident edge.
            if (rel) begin
              state        <= IDLE;
              tone_present <= 1'b0;
              match_cnt    <= '0;
            end else if (p_ok) begin
              ref_p <= cnt;
              if (!p_match) begin
                state        <= TRACK;
                match_cnt    <= MW'(1);
                tone_present <= 1'b0;
              end else if (state == TRACK) begin
                match_cnt <= match_cnt + 1'b1;
                if (32'(match_cnt) + 1 == LOCK_COUNT) begin
                  state        <= LOCKED;
                  tone_present <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule
